pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the single-cycle RV32I core. Holds the architectural PC, runs a req/ready fetch handshake to instruction memory, presents the fetched instruction to decode, and applies the 2-bit `pc_control` select from the PC-source control logic to choose the next PC. It also counts retired instructions and optionally traps on misaligned targets.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: req/ready fetch, next-PC select, retire count.
// Optional macro PC_MISALIGN_TRAP_EN: halt on a misaligned next PC instead of truncating it.
//
// state | meaning
// BOOT  | one idle cycle after reset
// REQ   | imem_req high, waiting for imem_ready
// EXEC  | instr valid for decode; commits next PC unless stalled
// HALT  | misaligned-target trap, terminal until reset
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_control,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret,
  output logic        misaligned,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, instr_q, instret_q;
  logic [31:0] target, pc_commit;
  logic        target_bad, commit;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    target = pc_plus4;
    case (pc_control)
      2'b00:   target = pc_plus4;
      2'b01:   target = branch_target;
      2'b10:   target = jal_target;
      default: target = jalr_target & ~32'h1;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign target_bad = (target[1:0] != 2'b00);
  assign pc_commit  = target;
`else
  assign target_bad = 1'b0;
  assign pc_commit  = target & ~32'h3;
`endif

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ:  if (imem_ready) state_nxt = S_EXEC;
      S_EXEC: begin
        if (!stall) begin
          if (target_bad) begin
            state_nxt = S_HALT;
          end else begin
            commit    = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_BOOT;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'h0000_0013;
      instret_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ && imem_ready) instr_q <= imem_rdata;
      if (commit) begin
        pc_q      <= pc_commit;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state == S_EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instret     = instret_q;

  // HALT is only reachable through a trap, so both flags are the HALT state itself.
`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = (state == S_HALT);
  assign halted     = (state == S_HALT);
`else
  assign misaligned = 1'b0;
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit with RESET_VECTOR = 0x1000.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV   = 32'h0000_1000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_control;
  logic [31:0] branch_target, jal_target, jalr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4, instret;
  logic        misaligned, halted;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .pc_control(pc_control),
    .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .instret(instret),
    .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [31:0] rdata;
    logic        stl;
    logic [1:0]  ctl;
    logic [31:0] br;
    logic [31:0] jal;
    logic [31:0] jalr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_instret;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t v(input logic rdy, input logic [31:0] rdata, input logic stl,
                             input logic [1:0] ctl, input logic [31:0] br, input logic [31:0] jal,
                             input logic [31:0] jalr, input logic e_req, input logic e_valid,
                             input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_instret);
    vec_t r;
    r.rdy = rdy; r.rdata = rdata; r.stl = stl; r.ctl = ctl;
    r.br = br; r.jal = jal; r.jalr = jalr;
    r.e_req = e_req; r.e_valid = e_valid; r.e_pc = e_pc;
    r.e_instr = e_instr; r.e_instret = e_instret;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " imem_req"},    {31'd0, imem_req}, 32'd0);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, " pc"},          pc, RV);
    chk({tag, " imem_addr"},   imem_addr, RV);
    chk({tag, " pc_plus4"},    pc_plus4, RV + 32'd4);
    chk({tag, " instr"},       instr, NOP);
    chk({tag, " instret"},     instret, 32'd0);
    chk({tag, " misaligned"},  {31'd0, misaligned}, 32'd0);
    chk({tag, " halted"},      {31'd0, halted}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = JUNK; stall = 1'b0;
    pc_control = 2'b00; branch_target = 32'h444; jal_target = 32'h888; jalr_target = 32'hCCD;

    vecs[0]  = v(1, JUNK,          0, 2'b01, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1000, NOP,           0);
    vecs[1]  = v(1, 32'h00100093,  1, 2'b01, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h1000, 32'h00100093,  0);
    vecs[2]  = v(1, JUNK,          0, 2'b00, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1004, 32'h00100093,  1);
    vecs[3]  = v(1, 32'h00200113,  0, 2'b11, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h1004, 32'h00200113,  1);
    vecs[4]  = v(0, JUNK,          0, 2'b00, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1008, 32'h00200113,  2);
    vecs[5]  = v(0, JUNK,          0, 2'b01, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1008, 32'h00200113,  2);
    vecs[6]  = v(0, JUNK,          0, 2'b01, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1008, 32'h00200113,  2);
    vecs[7]  = v(0, JUNK,          0, 2'b01, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h1008, 32'h00200113,  2);
    vecs[8]  = v(1, 32'h00A00093,  0, 2'b01, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h1008, 32'h00A00093,  2);
    vecs[9]  = v(0, JUNK,          0, 2'b00, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h100C, 32'h00A00093,  3);
    vecs[10] = v(1, 32'h00300193,  0, 2'b00, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h100C, 32'h00300193,  3);
    vecs[11] = v(0, JUNK,          0, 2'b10, 32'h444, 32'h100, 32'hCCD, 1, 0, 32'h0100, 32'h00300193,  4);
    vecs[12] = v(1, 32'h00400213,  0, 2'b00, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h0100, 32'h00400213,  4);
    vecs[13] = v(1, JUNK,          1, 2'b01, 32'h080, 32'h888, 32'hCCD, 0, 1, 32'h0100, 32'h00400213,  4);
    vecs[14] = v(1, JUNK,          1, 2'b01, 32'h080, 32'h888, 32'hCCD, 0, 1, 32'h0100, 32'h00400213,  4);
    vecs[15] = v(0, JUNK,          0, 2'b01, 32'h080, 32'h888, 32'hCCD, 1, 0, 32'h0080, 32'h00400213,  5);
    vecs[16] = v(1, 32'h00500293,  0, 2'b00, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h0080, 32'h00500293,  5);
    vecs[17] = v(0, JUNK,          0, 2'b11, 32'h444, 32'h888, 32'h205, 1, 0, 32'h0204, 32'h00500293,  6);
    vecs[18] = v(1, 32'h00600313,  0, 2'b00, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'h0204, 32'h00600313,  6);
    vecs[19] = v(0, JUNK,          0, 2'b10, 32'h444, 32'hFFFF_FFFC, 32'hCCD, 1, 0, 32'hFFFF_FFFC, 32'h00600313, 7);
    vecs[20] = v(1, 32'h00700393,  0, 2'b00, 32'h444, 32'h888, 32'hCCD, 0, 1, 32'hFFFF_FFFC, 32'h00700393, 7);
    vecs[21] = v(0, JUNK,          0, 2'b00, 32'h444, 32'h888, 32'hCCD, 1, 0, 32'h0000_0000, 32'h00700393, 8);

    // Reset with imem_ready high: nothing may be captured or requested.
    step(); step();
    chk_reset_values("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rdata; stall = vecs[i].stl;
      pc_control = vecs[i].ctl; branch_target = vecs[i].br;
      jal_target = vecs[i].jal; jalr_target = vecs[i].jalr;
      step();
      chk($sformatf("v%0d imem_req", i),    {31'd0, imem_req},    {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d pc", i),          pc,                   vecs[i].e_pc);
      chk($sformatf("v%0d imem_addr", i),   imem_addr,            vecs[i].e_pc);
      chk($sformatf("v%0d pc_plus4", i),    pc_plus4,             vecs[i].e_pc + 32'd4);
      chk($sformatf("v%0d instr", i),       instr,                vecs[i].e_instr);
      chk($sformatf("v%0d instret", i),     instret,              vecs[i].e_instret);
    end

    // Misaligned jal target from pc 0x100.
    stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h00100093; pc_control = 2'b00;
    step();
    pc_control = 2'b10; jal_target = 32'h100; imem_ready = 1'b0;
    step();
    chk("mis setup pc", pc, 32'h100);
    chk("mis setup instret", instret, 32'd9);
    imem_ready = 1'b1; imem_rdata = 32'h0020006F; pc_control = 2'b00;
    step();
    chk("mis exec valid", {31'd0, instr_valid}, 32'd1);
    pc_control = 2'b10; jal_target = 32'h102; imem_ready = 1'b0;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap halted",     {31'd0, halted},     32'd1);
    chk("trap misaligned", {31'd0, misaligned}, 32'd1);
    chk("trap pc",         pc,                  32'h100);
    chk("trap imem_req",   {31'd0, imem_req},   32'd0);
    chk("trap instret",    instret,             32'd9);
    imem_ready = 1'b1; pc_control = 2'b00;
    step(); step();
    chk("halt sticky halted",     {31'd0, halted},     32'd1);
    chk("halt sticky misaligned", {31'd0, misaligned}, 32'd1);
    chk("halt sticky pc",         pc,                  32'h100);
    chk("halt sticky imem_req",   {31'd0, imem_req},   32'd0);
    chk("halt sticky valid",      {31'd0, instr_valid}, 32'd0);
`else
    chk("mis imem_addr",   imem_addr,           32'h100);
    chk("mis imem_req",    {31'd0, imem_req},   32'd1);
    chk("mis instret",     instret,             32'd10);
    chk("mis halted",      {31'd0, halted},     32'd0);
    chk("mis misaligned",  {31'd0, misaligned}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h00300193; pc_control = 2'b00;
    step();
    chk("mis cont instr", instr, 32'h00300193);
    step();
    chk("mis cont pc", pc, 32'h104);
`endif

    // Reset, then reset again while REQ is waiting on imem_ready.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; imem_ready = 1'b0;
    step();
    step();
    chk("midrst pre req",  {31'd0, imem_req}, 32'd1);
    chk("midrst pre addr", imem_addr, RV);
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h00F00F93;
    step();
    chk_reset_values("midrst");
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h00300193;
    step();
    chk("restart req",  {31'd0, imem_req}, 32'd1);
    chk("restart addr", imem_addr, RV);
    step();
    chk("restart instr", instr, 32'h00300193);

    // instret wraps from all-ones to zero on the next commit.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    pc_control = 2'b00; imem_ready = 1'b0;
    step();
    chk("wrap instret", instret, 32'd0);
    chk("wrap pc", pc, RV + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
